// File: rtl/fetch_stage_pkg.sv
// Shared widths, reset/halt constants, run state and next-PC select encodings for fetch_stage.
package fetch_stage_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned INST_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam logic [3:0] HALT_OPCODE = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_JUMP   = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_HOLD   = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC priority mux (hold > jump > branch > sequential) with wrap-around PC adders; pure combinational.
module fetch_stage_next_pc_sel
  import fetch_stage_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_valid,
  input  logic              hold,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  output pc_sel_e           sel,
  output logic [ADDR_W-1:0] next_pc,
  output logic              squash
);

  always_comb begin
    sel    = SEL_SEQ;
    squash = 1'b0;
    if (hold) begin
      sel = SEL_HOLD;
    end else if (ir_valid && jump) begin
      sel    = SEL_JUMP;
      squash = 1'b1;
    end else if (ir_valid && branch_taken) begin
      sel    = SEL_BRANCH;
      squash = 1'b1;
    end
  end

  // An ADDR_W-bit add is both the sign extension and the modulo wrap.
  always_comb begin
    next_pc = pc;
    case (sel)
      SEL_SEQ:    next_pc = pc + ADDR_W'(1);
      SEL_JUMP:   next_pc = jump_target;
      SEL_BRANCH: next_pc = ir_pc + branch_offset;
      SEL_HOLD:   next_pc = pc;
      default:    next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// PC + instruction register stage: one-edge fetch latency, Stall holds everything, redirects cost one bubble, halt freezes until Rst.
// Build with FETCH_PERF_EN for saturating Fetch_Count / Squash_Count; otherwise those ports read 0.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  output logic [ADDR_W-1:0] Address,
  input  logic [INST_W-1:0] Instruction,
  input  logic              Stall,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] Jump_Target,
  input  logic              Branch_Taken,
  input  logic [ADDR_W-1:0] Branch_Offset,
  output logic [INST_W-1:0] IR,
  output logic [ADDR_W-1:0] IR_PC,
  output logic              IR_Valid,
  output logic              Halted,
  output logic [15:0]       Fetch_Count,
  output logic [15:0]       Squash_Count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] ir_q;
  logic [ADDR_W-1:0] ir_pc_q;
  logic              ir_valid_q;
  logic              halt_hit;
  logic              hold;
  pc_sel_e           sel;
  logic [ADDR_W-1:0] next_pc;
  logic              squash;
  logic              load;

  assign halt_hit = ir_valid_q && (ir_q[INST_W-1 -: 4] == HALT_OPCODE) && !Stall;
  // The halt edge and the halted state both freeze PC on the halt's successor.
  assign hold     = Stall || halt_hit || (state_q == ST_HALT);
  assign load     = (sel == SEL_SEQ);

  fetch_stage_next_pc_sel u_next_pc_sel (
    .pc            (pc_q),
    .ir_pc         (ir_pc_q),
    .ir_valid      (ir_valid_q),
    .hold          (hold),
    .jump          (Jump),
    .jump_target   (Jump_Target),
    .branch_taken  (Branch_Taken),
    .branch_offset (Branch_Offset),
    .sel           (sel),
    .next_pc       (next_pc),
    .squash        (squash)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    Halted  = 1'b0;
    case (state_q)
      ST_RUN:  if (halt_hit) state_d = ST_HALT;
      ST_HALT: Halted = 1'b1;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q <= next_pc;
      if (halt_hit || state_q == ST_HALT) begin
        ir_valid_q <= 1'b0;
      end else if (load) begin
        ir_q       <= Instruction;
        ir_pc_q    <= pc_q;
        ir_valid_q <= 1'b1;
      end else if (squash) begin
        ir_valid_q <= 1'b0;
      end
    end
  end

  assign Address  = pc_q;
  assign IR       = ir_q;
  assign IR_PC    = ir_pc_q;
  assign IR_Valid = ir_valid_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] squash_cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (load && fetch_cnt_q != 16'hFFFF)    fetch_cnt_q  <= fetch_cnt_q + 16'd1;
      if (squash && squash_cnt_q != 16'hFFFF) squash_cnt_q <= squash_cnt_q + 16'd1;
    end
  end

  assign Fetch_Count  = fetch_cnt_q;
  assign Squash_Count = squash_cnt_q;
`else
  assign Fetch_Count  = '0;
  assign Squash_Count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: spec-level model checked every cycle plus hand-computed literals.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  address;
  logic [15:0] instruction;
  logic        stall;
  logic        jump;
  logic [9:0]  jump_target;
  logic        branch_taken;
  logic [9:0]  branch_offset;
  logic [15:0] ir;
  logic [9:0]  ir_pc;
  logic        ir_valid;
  logic        halted;
  logic [15:0] fetch_count;
  logic [15:0] squash_count;

  logic [15:0] mem [0:1023];
  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  // Model state
  logic [9:0]  m_pc = '0;
  logic [15:0] m_ir = '0;
  logic [9:0]  m_irpc = '0;
  logic        m_vld = 1'b0;
  logic        m_halt = 1'b0;
  int          m_fc = 0;
  int          m_sc = 0;

  always #5 clk = ~clk;

  assign instruction = mem[address];

  fetch_stage dut (
    .Clk           (clk),
    .Rst           (rst),
    .Address       (address),
    .Instruction   (instruction),
    .Stall         (stall),
    .Jump          (jump),
    .Jump_Target   (jump_target),
    .Branch_Taken  (branch_taken),
    .Branch_Offset (branch_offset),
    .IR            (ir),
    .IR_PC         (ir_pc),
    .IR_Valid      (ir_valid),
    .Halted        (halted),
    .Fetch_Count   (fetch_count),
    .Squash_Count  (squash_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model straight from the stage rules.
  always @(posedge clk) begin
    if (rst) begin
      m_pc = '0; m_ir = '0; m_irpc = '0; m_vld = 1'b0; m_halt = 1'b0; m_fc = 0; m_sc = 0;
    end else if (m_halt) begin
      m_vld = 1'b0;
    end else if (m_vld && m_ir[15:12] == 4'hF && !stall) begin
      m_halt = 1'b1;
      m_vld  = 1'b0;
    end else if (stall) begin
      m_vld = m_vld;
    end else if (m_vld && (jump || branch_taken)) begin
      m_pc  = jump ? jump_target : m_irpc + branch_offset;
      m_vld = 1'b0;
      if (m_sc < 65535) m_sc++;
    end else begin
      m_ir   = mem[m_pc];
      m_irpc = m_pc;
      m_vld  = 1'b1;
      m_pc   = m_pc + 10'd1;
      if (m_fc < 65535) m_fc++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("addr", 32'(address), 32'(m_pc));
      chk("ir_valid", 32'(ir_valid), 32'(m_vld));
      chk("halted", 32'(halted), 32'(m_halt));
      if (m_vld) begin
        chk("ir", 32'(ir), 32'(m_ir));
        chk("ir_pc", 32'(ir_pc), 32'(m_irpc));
      end
`ifdef FETCH_PERF_EN
      chk("fetch_count", 32'(fetch_count), 32'(m_fc));
      chk("squash_count", 32'(squash_count), 32'(m_sc));
`else
      chk("fetch_count", 32'(fetch_count), 32'd0);
      chk("squash_count", 32'(squash_count), 32'd0);
`endif
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string name, input int fc, input int sc);
`ifdef FETCH_PERF_EN
    chk({name, "_fc"}, 32'(fetch_count), 32'(fc));
    chk({name, "_sc"}, 32'(squash_count), 32'(sc));
`else
    chk({name, "_fc"}, 32'(fetch_count), 32'd0);
    chk({name, "_sc"}, 32'(squash_count), 32'd0);
`endif
  endtask

  task automatic chk_ir(input string name, input logic [15:0] e_ir, input logic [9:0] e_pc,
                        input logic [9:0] e_addr);
    chk({name, "_ir"}, 32'(ir), 32'(e_ir));
    chk({name, "_irpc"}, 32'(ir_pc), 32'(e_pc));
    chk({name, "_vld"}, 32'(ir_valid), 32'd1);
    chk({name, "_addr"}, 32'(address), 32'(e_addr));
  endtask

  task automatic chk_bubble(input string name, input logic [9:0] e_addr);
    chk({name, "_vld"}, 32'(ir_valid), 32'd0);
    chk({name, "_addr"}, 32'(address), 32'(e_addr));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i) + 16'd1;
    rst = 1'b1; stall = 1'b0; jump = 1'b0; jump_target = '0;
    branch_taken = 1'b0; branch_offset = '0;

    // Phase A: reset, free run, stall, redirects, wrap
    tick(2);
    started = 1'b1;
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_vld", 32'(ir_valid), 32'd0);
    chk("rst_halt", 32'(halted), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_irpc", 32'(ir_pc), 32'd0);
    chk_cnt("rst", 0, 0);
    rst = 1'b0;
    tick(); chk_ir("run0", 16'h1001, 10'd0, 10'd1);
    tick(); chk_ir("run1", 16'h1002, 10'd1, 10'd2);
    stall = 1'b1;
    tick(3); chk_ir("stall", 16'h1002, 10'd1, 10'd2);
    stall = 1'b0;
    tick(); chk_ir("resume", 16'h1003, 10'd2, 10'd3);
    tick(3); chk_ir("at5", 16'h1006, 10'd5, 10'd6);
    branch_taken = 1'b1; branch_offset = 10'h3FE;
    tick(); chk_bubble("br_back", 10'd3);
    branch_taken = 1'b0;
    tick(); chk_ir("br_land", 16'h1004, 10'd3, 10'd4);
    jump = 1'b1; jump_target = 10'd1023;
    tick(); chk_bubble("jmp_top", 10'd1023);
    jump = 1'b0;
    tick(); chk_ir("wrap", 16'h1400, 10'd1023, 10'd0);
    jump = 1'b1; jump_target = 10'd100; branch_taken = 1'b1; branch_offset = 10'd5;
    tick(); chk_bubble("jmp_wins", 10'd100);
    jump = 1'b0; branch_taken = 1'b0;
    tick(); chk_ir("jmp_land", 16'h1065, 10'd100, 10'd101);
    jump = 1'b1; jump_target = 10'd200;
    tick(); chk_bubble("jmp200", 10'd200);
    jump_target = 10'd300;
    tick(); chk_ir("ignored", 16'h10C9, 10'd200, 10'd201);
    jump_target = 10'd0;
    tick(); chk_bubble("jmp0", 10'd0);
    jump = 1'b0;
    tick(); chk_ir("at0", 16'h1001, 10'd0, 10'd1);
    branch_taken = 1'b1; branch_offset = 10'h3FF;
    tick(); chk_bubble("br_neg_wrap", 10'd1023);
    branch_taken = 1'b0;
    tick(); chk_ir("br_wrap_land", 16'h1400, 10'd1023, 10'd0);
    chk_cnt("phaseA", 12, 6);

    // Phase B: halt at address 4, Rst exits
    rst = 1'b1; mem[4] = 16'hF000;
    tick();
    chk("rstB_addr", 32'(address), 32'd0);
    chk_cnt("rstB", 0, 0);
    rst = 1'b0;
    tick(5); chk_ir("halt_in_ir", 16'hF000, 10'd4, 10'd5);
    tick(); chk("halt_set", 32'(halted), 32'd1);
    chk_bubble("halt_frz", 10'd5);
    tick(2); chk_bubble("halt_hold", 10'd5);
    chk("halt_ir", 32'(ir), 32'hF000);
    chk("halt_stay", 32'(halted), 32'd1);
    chk_cnt("halt", 5, 0);
    rst = 1'b1;
    tick(); chk("halt_rst", 32'(halted), 32'd0);
    chk("halt_rst_addr", 32'(address), 32'd0);

    // Phase C: wrong-path halt word squashed by a jump
    rst = 1'b0;
    tick(4); chk_ir("pre_sq", 16'h1004, 10'd3, 10'd4);
    jump = 1'b1; jump_target = 10'd10;
    tick(); chk_bubble("sq_halt", 10'd10);
    jump = 1'b0;
    tick(); chk_ir("after_sq", 16'h100B, 10'd10, 10'd11);
    chk("no_halt", 32'(halted), 32'd0);
    branch_taken = 1'b1; branch_offset = 10'h3F8;
    tick(); chk_bubble("br_m8", 10'd2);
    chk_cnt("perf", 5, 2);
    branch_taken = 1'b0;
    tick(); chk_ir("c_land", 16'h1003, 10'd2, 10'd3);
    tick(4);
    chk("c_halt", 32'(halted), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Program-counter and fetch-register stage directly upstream of the instruction memory and directly downstream of it toward decode.
- Drives the 10-bit instruction address, latches the returned 16-bit word into an instruction register (IR), and hands IR plus its PC to decode.
- Handles stall, jump/branch redirect with squash of the wrong-path fetch, and halt detection.

Parameters:
- ADDR_W, 10, PC / instruction address width.
- INST_W, 16, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OPCODE, 4'hF, value of Instruction[15:12] that marks a halt.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- Address  out  ADDR_W  fetch address to instruction memory; equals PC combinationally.
- Instruction  in  INST_W  word returned by instruction memory; combinational in Address.
- Stall  in  1  decode/hazard hold request.
- Jump  in  1  absolute redirect request for the instruction in IR.
- Jump_Target  in  ADDR_W  absolute target.
- Branch_Taken  in  1  relative redirect request for the instruction in IR.
- Branch_Offset  in  ADDR_W  signed two's-complement offset.
- IR  out  INST_W  latched instruction to decode.
- IR_PC  out  ADDR_W  address IR was fetched from.
- IR_Valid  out  1  IR holds a valid, non-squashed instruction.
- Halted  out  1  stage stopped on a halt instruction.
- Fetch_Count  out  16  performance counter; see Optional Feature.
- Squash_Count  out  16  performance counter; see Optional Feature.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high (Rst).
- Reset: PC=RESET_PC, IR=0, IR_PC=0, IR_Valid=0, Halted=0, state=RUN, counters=0.
- Rst overrides everything, including mid-stall, mid-redirect and HALT.
- States: RUN and HALT.
- RUN, per edge, priority top-down:
  - Stall=1: PC, IR, IR_PC and IR_Valid hold. Jump/Branch_Taken are ignored; decode must reassert them after the stall.
  - IR_Valid=1 and Jump=1: PC<=Jump_Target; IR_Valid<=0 (wrong-path fetch squashed).
  - IR_Valid=1 and Branch_Taken=1: PC<=IR_PC+sign_ext(Branch_Offset), mod 2^ADDR_W; IR_Valid<=0.
  - Otherwise: IR<=Instruction, IR_PC<=PC, IR_Valid<=1, PC<=PC+1.
- Jump and Branch_Taken together: Jump wins.
- Redirect requests while IR_Valid=0 are ignored.
- PC arithmetic wraps: 1023+1 -> 0; 0 + (-1) -> 1023.
- Latency: an instruction at address A appears in IR with IR_Valid=1 one edge after PC=A with no stall/redirect. First valid IR is the 1st edge after Rst falls.
- Redirect penalty: exactly one bubble (IR_Valid=0 for one cycle).
- Halt: while IR_Valid=1, IR[15:12]==HALT_OPCODE and Stall=0, the next edge enters HALT.
  - In HALT: Halted=1, IR_Valid=0, PC/IR/IR_PC frozen, Address stays on the halt's successor. Only Rst exits HALT.
- A halt word fetched on a wrong path is squashed by the redirect and never halts.
- Address is purely combinational from PC; no registering. Instruction memory must be valid from the first cycle after Rst.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Fetch_Count increments on every edge that loads IR with IR_Valid<=1.
  - Squash_Count increments on every accepted redirect.
  - Both saturate at 16'hFFFF and clear on Rst.
- Undefined: the counter logic is not built; both ports are tied to 0 so the interface is unchanged.

Decomposition:
- Shared package holds ADDR_W, INST_W, RESET_PC, HALT_OPCODE, the RUN/HALT state encoding, and a next-PC select enum (SEQ, JUMP, BRANCH, HOLD).
- One natural sub-module: next_pc_sel, a combinational priority mux plus wrap-around adder producing the next PC and the squash flag.
- Counters stay inline under FETCH_PERF_EN.

Test Plan:
- Reset then free-run with memory words 0x1001, 0x1002, 0x1003 at 0..2 -> Address 0,1,2,3 on successive cycles; IR 0x1001/0x1002/0x1003 with IR_PC 0,1,2; IR_Valid high from the 1st edge.
- Stall=1 for 3 cycles while IR=0x1002 -> PC, IR and IR_PC unchanged; resume -> next IR 0x1003 with no loss or duplication.
- IR at PC 5 with Branch_Taken=1, offset 10'h3FE (-2) -> one bubble (IR_Valid=0); next Address=3; the wrong-path word from 6 never appears valid.
- Jump=1 with Jump_Target=1023, then free-run -> Address 1023, then 0 (wrap); Jump+Branch_Taken together -> Jump target used.
- Halt word 0xF000 at address 4 -> IR=0xF000 valid for one cycle, then Halted=1, IR_Valid=0, Address frozen; Rst -> Halted=0, Address=0. A wrong-path 0xF000 squashed by a jump never sets Halted.
- With FETCH_PERF_EN: 5 fetches and 2 redirects -> Fetch_Count=5, Squash_Count=2. Without the macro: both read 0.
